// File: rtl/pipe_scoreboard_if.sv
// Issue/hazard bus between decode and the pipeline scoreboard.
// The scoreboard takes the slave side; decode/control logic takes the master side.
interface pipe_scoreboard_if #(
   parameter int STAGES = 3,
   parameter int REGW   = 5,
   parameter int CNTW   = 16
);
   localparam int SELW = $clog2(STAGES + 1);

   logic              advance;
   logic [STAGES-1:0] flush;
   logic              issue_valid;
   logic [REGW-1:0]   issue_rs;
   logic [REGW-1:0]   issue_rt;
   logic              issue_use_rs;
   logic              issue_use_rt;
   logic              issue_wr;
   logic [REGW-1:0]   issue_wsel;
   logic              issue_load;
   logic              stall;
   logic [SELW-1:0]   fwd_rs_sel;
   logic [SELW-1:0]   fwd_rt_sel;
   logic [SELW-1:0]   inflight;
   logic [CNTW-1:0]   stall_count;

   modport master (
      output advance, flush, issue_valid, issue_rs, issue_rt, issue_use_rs,
             issue_use_rt, issue_wr, issue_wsel, issue_load,
      input  stall, fwd_rs_sel, fwd_rt_sel, inflight, stall_count
   );

   modport slave (
      input  advance, flush, issue_valid, issue_rs, issue_rt, issue_use_rs,
             issue_use_rt, issue_wr, issue_wsel, issue_load,
      output stall, fwd_rs_sel, fwd_rt_sel, inflight, stall_count
   );
endinterface

// File: rtl/pipe_scoreboard.sv
// Hazard detection and forwarding-select unit: tracks destination registers of
// in-flight instructions over STAGES stages and drives stall / forwarding selects.
module pipe_scoreboard #(
   parameter int STAGES     = 3,
   parameter int LOAD_STAGE = 1,
   parameter int REGW       = 5,
   parameter int CNTW       = 16
) (
   input logic              CLK,
   input logic              RST,
   pipe_scoreboard_if.slave bus
);
   localparam int          SELW   = $clog2(STAGES + 1);
   localparam int unsigned LOAD_U = LOAD_STAGE;

   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] ld;
   logic [REGW-1:0]   wsel [STAGES];
   logic [CNTW-1:0]   cnt;
   logic [SELW:0]     rs_res;
   logic [SELW:0]     rt_res;
   logic              stall_i;
   logic              accept;

   // Youngest matching entry wins; returns {load_hazard, forward_select}.
   function automatic logic [SELW:0] lookup(
      input logic              use_s,
      input logic [REGW-1:0]   s,
      input logic [STAGES-1:0] v,
      input logic [STAGES-1:0] l,
      input logic [REGW-1:0]   w [STAGES]
   );
      logic            found;
      logic            haz;
      logic [SELW-1:0] sel;
      found = 1'b0;
      haz   = 1'b0;
      sel   = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         if (!found && use_s && (s != '0) && v[k] && (w[k] == s)) begin
            found = 1'b1;
            haz   = l[k] && (k < LOAD_U);
            sel   = haz ? '0 : SELW'(k + 1);
         end
      end
      return {haz, sel};
   endfunction

   always_comb begin
      rs_res  = lookup(bus.issue_use_rs, bus.issue_rs, vld, ld, wsel);
      rt_res  = lookup(bus.issue_use_rt, bus.issue_rt, vld, ld, wsel);
      stall_i = bus.issue_valid && (rs_res[SELW] || rt_res[SELW]);
      accept  = bus.issue_valid && !stall_i && !bus.flush[0] &&
                bus.issue_wr && (bus.issue_wsel != '0);
   end

   always_comb begin
      bus.inflight = '0;
      for (int unsigned k = 0; k < STAGES; k++)
         bus.inflight = bus.inflight + SELW'(vld[k]);
   end

   assign bus.stall       = stall_i;
   assign bus.fwd_rs_sel  = rs_res[SELW-1:0];
   assign bus.fwd_rt_sel  = rt_res[SELW-1:0];
   assign bus.stall_count = cnt;

   // Flush applies to the value landing in each slot, whether shifted or held.
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld <= '0;
      end else if (bus.advance) begin
         vld[0] <= accept;
         for (int unsigned k = 1; k < STAGES; k++)
            vld[k] <= vld[k-1] && !bus.flush[k];
      end else begin
         vld <= vld & ~bus.flush;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ld <= '0;
      end else if (bus.advance) begin
         ld[0]   <= bus.issue_load;
         wsel[0] <= bus.issue_wsel;
         for (int unsigned k = 1; k < STAGES; k++) begin
            ld[k]   <= ld[k-1];
            wsel[k] <= wsel[k-1];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST)
         cnt <= '0;
      else if (stall_i && bus.advance && (cnt != '1))
         cnt <= cnt + 1'b1;
   end
endmodule
